// File: rtl/organ_harmonizer_axil_regs.sv
// OrganHarmonizer AXI4-Lite register bank.
// Control registers, write strobes and S00_AXI responder.
module organ_harmonizer_axil_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int NUM_REGS           = 4
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_q,
  output logic [NUM_REGS-1:0]             reg_wr
);

  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int AW = C_S_AXI_ADDR_WIDTH;
  localparam int SW = DW / 8;
  localparam int IW = AW - 2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [DW-1:0] regs [NUM_REGS];

  logic          aw_held;
  logic          w_held;
  logic [AW-1:0] aw_addr_q;
  logic [DW-1:0] w_data_q;
  logic [SW-1:0] w_strb_q;

  logic          aw_hs;
  logic          w_hs;
  logic          ar_hs;
  logic          commit;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [SW-1:0] wr_strb;
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] rd_idx;
  logic          wr_ok;
  logic          rd_ok;
  logic [DW-1:0] rd_val;
  logic          unused_ok;

  assign S_AXI_AWREADY = !aw_held && !S_AXI_BVALID;
  assign S_AXI_WREADY  = !w_held && !S_AXI_BVALID;
  assign S_AXI_ARREADY = !S_AXI_RVALID;

  assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs  = S_AXI_WVALID && S_AXI_WREADY;
  assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

  // A held half always wins over the live bus for the same channel.
  assign wr_addr = aw_held ? aw_addr_q : S_AXI_AWADDR;
  assign wr_data = w_held ? w_data_q : S_AXI_WDATA;
  assign wr_strb = w_held ? w_strb_q : S_AXI_WSTRB;

  assign commit = (aw_held || aw_hs) && (w_held || w_hs);

  assign wr_idx = wr_addr[AW-1:2];
  assign rd_idx = S_AXI_ARADDR[AW-1:2];
  assign wr_ok  = 32'(wr_idx) < 32'(NUM_REGS);
  assign rd_ok  = 32'(rd_idx) < 32'(NUM_REGS);

  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                       wr_addr[1:0], S_AXI_ARADDR[1:0]};

  genvar g;
  for (g = 0; g < NUM_REGS; g++) begin : g_q
    assign reg_q[DW*g +: DW] = regs[g];
  end

  // Read mux over implemented registers only.
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_idx == IW'(i)) begin
        rd_val = regs[i];
      end
    end
  end

  // Capture the address and data halves independently until commit.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
    end else if (commit) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
    end else begin
      if (aw_hs) begin
        aw_held   <= 1'b1;
        aw_addr_q <= S_AXI_AWADDR;
      end
      if (w_hs) begin
        w_held   <= 1'b1;
        w_data_q <= S_AXI_WDATA;
        w_strb_q <= S_AXI_WSTRB;
      end
    end
  end

  // Byte-lane register update and one-cycle write strobe.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
      reg_wr <= '0;
    end else begin
      reg_wr <= '0;
      if (commit && wr_ok) begin
        for (int i = 0; i < NUM_REGS; i++) begin
          if (wr_idx == IW'(i)) begin
            reg_wr[i] <= 1'b1;
            for (int b = 0; b < SW; b++) begin
              if (wr_strb[b]) begin
                regs[i][8*b +: 8] <= wr_data[8*b +: 8];
              end
            end
          end
        end
      end
    end
  end

  // Write response channel.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      S_AXI_BVALID <= 1'b0;
      S_AXI_BRESP  <= RESP_OKAY;
    end else if (commit) begin
      S_AXI_BVALID <= 1'b1;
      S_AXI_BRESP  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
    end else if (S_AXI_BREADY) begin
      S_AXI_BVALID <= 1'b0;
    end
  end

  // Read channel; sampling pre-edge regs gives pre-write data.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      S_AXI_RVALID <= 1'b0;
      S_AXI_RDATA  <= '0;
      S_AXI_RRESP  <= RESP_OKAY;
    end else if (ar_hs) begin
      S_AXI_RVALID <= 1'b1;
      S_AXI_RDATA  <= rd_ok ? rd_val : '0;
      S_AXI_RRESP  <= rd_ok ? RESP_OKAY : RESP_SLVERR;
    end else if (S_AXI_RREADY) begin
      S_AXI_RVALID <= 1'b0;
    end
  end

endmodule
